regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; register count NREG = 2**ADDR_W.
REQ-003 Parameter NRD, default 3, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low.
REQ-007 ready  out  1  high when the init sweep is done and the block accepts traffic.
REQ-008 rd_en  in  NRD  per-port read enable.
REQ-009 rd_addr  in  NRD*ADDR_W  per-port read address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 rd_data  out  NRD*DATA_W  per-port combinational read data.
REQ-011 rd_busy  out  NRD  per-port scoreboard pending bit for rd_addr.
REQ-012 wr_en  in  NWR  per-port write enable.
REQ-013 wr_addr  in  NWR*ADDR_W  per-port write address.
REQ-014 wr_data  in  NWR*DATA_W  per-port write data.
REQ-015 sb_set  in  1  marks register sb_addr as pending (producer issued).
REQ-016 sb_addr  in  ADDR_W  scoreboard set address.

Function
REQ-017 FSM states: INIT, RUN. INIT on reset; RUN after the sweep completes; RUN is never left except by reset.
REQ-018 INIT: a counter starts at 1, writes zero to register[cnt] each cycle, and increments. Counter value NREG-1 is the last write, then the FSM enters RUN. The sweep takes NREG-1 cycles.
REQ-019 ready is 0 in INIT and 1 in RUN.
REQ-020 In INIT, wr_en and sb_set are ignored, and rd_data and rd_busy are all zero.
REQ-021 In RUN, write port j with wr_en[j]=1 and wr_addr!=0 updates its register at the clock edge.
REQ-022 If two write ports target the same address in the same cycle, the highest-index port wins.
REQ-023 Register 0 always reads zero and is never written, never marked busy, and never bypassed.
REQ-024 rd_data[i] is zero when rd_en[i]=0, when rd_addr[i]=0, or when the FSM is in INIT.
REQ-025 In RUN, sb_set with sb_addr!=0 sets busy[sb_addr] at the edge. Any write to address a clears busy[a] at the edge.
REQ-026 If a set and a clear hit the same address in the same cycle, the set wins and busy stays 1.
REQ-027 rd_busy[i] = busy[rd_addr[i]] & rd_en[i], and is zero for address 0.

Reset
REQ-028 rst low asynchronously forces: state INIT, counter 1, ready 0, all busy bits 0.
REQ-029 Register contents are not reset directly; the INIT sweep zeroes them.
REQ-030 rst asserted mid-sweep or mid-operation restarts the sweep from counter 1.

Configuration
REQ-031 Macro REGFILE_MP_BYPASS_EN.
- When defined: a read in RUN whose address matches an enabled same-cycle write returns that wr_data. Priority among matching writes follows REQ-022. rd_busy for that port is forced 0.
- When undefined: reads return stored contents only. The new value is visible the cycle after the write.

Structure
REQ-032 A shared package holds the default parameter constants, the zero-word constant, the register-0 address constant, and the FSM state encoding (INIT, RUN).
REQ-033 A single sub-module, regfile_mp_rdport, is instantiated NRD times. Each instance implements one read port's mux, bypass, and busy lookup.

Verification
REQ-034 Reset release -> ready=0 for exactly 31 cycles, then 1; every register then reads 0x00000000.
REQ-035 Port0 writes 0x11 and port1 writes 0x22 to x5 in the same cycle -> next cycle x5 reads 0x22.
REQ-036 Write x0=0xFFFFFFFF -> x0 reads 0. sb_set to x0 -> rd_busy stays 0.
REQ-037 sb_set x7, later write x7=0xA5 -> rd_busy on x7 is 1 until that edge, then 0. Set and write of x7 in the same cycle -> busy remains 1.
REQ-038 With BYPASS_EN: write x3=0xDEAD and read x3 in the same cycle -> 0xDEAD, rd_busy 0. Without it -> old value, then 0xDEAD next cycle.
REQ-039 rst pulsed low at sweep count 10 -> ready stays 0 for a full 31 cycles after release.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-ported register file: default parameter
// values, the zero word, the hard-wired register-0 address and the FSM
// state encoding.
package regfile_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 3;
  localparam int NWR_DEF    = 2;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;
  localparam logic [ADDR_W_DEF-1:0] REG0_ADDR = '0;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/regfile_mp_rdport.sv
// One read port of regfile_mp: zero forcing (INIT, disabled port, x0),
// optional same-cycle write bypass and the pending-bit lookup.
// Bypass is compiled in when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef REGFILE_MP_BYPASS_EN
  ,
  parameter int NWR    = NWR_DEF
`endif
) (
  input  logic                  run,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     stored_data,
  input  logic                  stored_busy,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic [NWR-1:0]        wr_vld,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
`endif
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_busy
);

  localparam logic [DATA_W-1:0] ZERO  = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] ADDR0 = ADDR_W'(REG0_ADDR);

  // Select the stored word (or a matching in-flight write) and gate to zero
  always_comb begin
    rd_data = ZERO;
    rd_busy = 1'b0;
    if (run && rd_en && (rd_addr != ADDR0)) begin
      rd_data = stored_data;
      rd_busy = stored_busy;
`ifdef REGFILE_MP_BYPASS_EN
      // later ports overwrite earlier ones, matching the write priority
      for (int j = 0; j < NWR; j++) begin
        if (wr_vld[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
          rd_data = wr_data[j*DATA_W +: DATA_W];
          rd_busy = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with a pending-write scoreboard.
// After reset an INIT sweep zeroes registers 1..NREG-1 (one per cycle),
// then the block stays in RUN until the next reset.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle
// writes to matching reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF,
  parameter int NWR    = NWR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_addr
);

  localparam int                NREG     = 2**ADDR_W;
  localparam logic [DATA_W-1:0] ZERO     = DATA_W'(ZERO_WORD);
  localparam logic [ADDR_W-1:0] ADDR0    = ADDR_W'(REG0_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  logic              run;
  logic [ADDR_W-1:0] wa [NWR];
  logic [DATA_W-1:0] wd [NWR];
  logic [NWR-1:0]    wv;

  assign run   = (state_q == ST_RUN);
  assign ready = run;

  // Unpack write ports; writes to x0 are dropped here once for everyone
  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*ADDR_W +: ADDR_W];
    assign wd[j] = wr_data[j*DATA_W +: DATA_W];
    assign wv[j] = wr_en[j] && (wa[j] != ADDR0);
  end

  // Sweep counter and INIT -> RUN transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // Scoreboard: writes clear, then set is applied last so it wins a tie
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int j = 0; j < NWR; j++) begin
        if (wv[j]) busy_d[wa[j]] = 1'b0;
      end
      if (sb_set && (sb_addr != ADDR0)) busy_d[sb_addr] = 1'b1;
    end
  end

  // Register array next value: sweep zeroing in INIT, port writes in RUN
  always_comb begin
    mem_d = mem_q;
    if (!run) begin
      mem_d[cnt_q] = ZERO;
    end else begin
      // ascending order lets the highest-index port win a collision
      for (int j = 0; j < NWR; j++) begin
        if (wv[j]) mem_d[wa[j]] = wd[j];
      end
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= ADDR_W'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Register storage is not reset; the INIT sweep clears it
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
`ifdef REGFILE_MP_BYPASS_EN
      ,
      .NWR    (NWR)
`endif
    ) u_rdport (
      .run         (run),
      .rd_en       (rd_en[i]),
      .rd_addr     (ra),
      .stored_data (mem_q[ra]),
      .stored_busy (busy_q[ra]),
`ifdef REGFILE_MP_BYPASS_EN
      .wr_vld      (wv),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
`endif
      .rd_data     (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy     (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a scoreboard queue of expected
// outputs that is drained at each sample point.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 3;
  localparam int NWR = 2;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              ready;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;

  regfile_mp dut (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .sb_set  (sb_set),
    .sb_addr (sb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_DATA  = 0;
  localparam int K_BUSY  = 1;
  localparam int K_READY = 2;

  typedef struct {
    string       tag;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      K_DATA:  return rd_data[port*DW +: DW];
      K_BUSY:  return {31'b0, rd_busy[port]};
      default: return {31'b0, ready};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.port = port;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.kind, e.port), e.exp);
    end
  endtask

  task automatic idle();
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
  endtask

  task automatic rd(input int p, input logic en, input logic [AW-1:0] a);
    rd_en[p]           = en;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic setb(input logic [AW-1:0] a);
    sb_set  = 1'b1;
    sb_addr = a;
  endtask

  // sample mid-cycle, then advance to 1 time unit after the next rising edge
  task automatic step();
    #3;
    drain();
    @(posedge clk);
    #1;
  endtask

  // count rising edges until ready, bounded
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        push({tag, "_init_ready"}, K_READY, 0, 32'h0);
        push({tag, "_init_data"},  K_DATA,  0, 32'h0);
        push({tag, "_init_busy"},  K_BUSY,  0, 32'h0);
        drain();
      end
    end
    chk({tag, "_len"}, 32'(n), 32'd31);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("ready_in_reset", K_READY, 0, 32'h0);
    drain();

    // traffic during INIT must be ignored
    rd(0, 1'b1, 5'd9);
    rd(1, 1'b1, 5'd9);
    rd(2, 1'b1, 5'd9);
    wr(0, 5'd9, 32'hFFFF_0000);
    wr(1, 5'd9, 32'h0000_FFFF);
    setb(5'd9);
    rst = 1'b1;
    wait_ready("sweep");
    idle();

    // every register zero after the sweep; x9 not busy
    for (int a = 0; a < 32; a++) begin
      rd(0, 1'b1, 5'(a));
      rd(1, 1'b1, 5'(31 - a));
      rd(2, 1'b1, 5'(a));
      push("zero_p0", K_DATA, 0, 32'h0);
      push("zero_p1", K_DATA, 1, 32'h0);
      push("zero_p2", K_DATA, 2, 32'h0);
      push("busy_after_init", K_BUSY, 0, 32'h0);
      step();
    end
    push("ready_run", K_READY, 0, 32'h1);
    drain();

    // same-address collision: highest port wins
    idle();
    wr(0, 5'd5, 32'h11);
    wr(1, 5'd5, 32'h22);
    rd(0, 1'b1, 5'd5);
    push("collide_same_cycle", K_DATA, 0, BYP ? 32'h22 : 32'h0);
    step();
    idle();
    rd(0, 1'b1, 5'd5);
    rd(1, 1'b1, 5'd5);
    rd(2, 1'b0, 5'd5);
    push("collide_p0", K_DATA, 0, 32'h22);
    push("collide_p1", K_DATA, 1, 32'h22);
    push("rd_en_off",  K_DATA, 2, 32'h0);
    step();

    // x0 is hard-wired
    idle();
    wr(1, 5'd0, 32'hFFFF_FFFF);
    setb(5'd0);
    rd(1, 1'b1, 5'd0);
    push("x0_same_data", K_DATA, 1, 32'h0);
    push("x0_same_busy", K_BUSY, 1, 32'h0);
    step();
    idle();
    rd(1, 1'b1, 5'd0);
    push("x0_data", K_DATA, 1, 32'h0);
    push("x0_busy", K_BUSY, 1, 32'h0);
    step();

    // scoreboard set, then write clears
    idle();
    setb(5'd7);
    step();
    idle();
    rd(1, 1'b1, 5'd7);
    rd(2, 1'b0, 5'd7);
    push("x7_busy_set", K_BUSY, 1, 32'h1);
    push("x7_busy_rden0", K_BUSY, 2, 32'h0);
    push("x7_old", K_DATA, 1, 32'h0);
    step();
    idle();
    wr(0, 5'd7, 32'hA5);
    rd(1, 1'b1, 5'd7);
    push("x7_busy_wr_cycle", K_BUSY, 1, BYP ? 32'h0 : 32'h1);
    push("x7_data_wr_cycle", K_DATA, 1, BYP ? 32'hA5 : 32'h0);
    step();
    idle();
    rd(1, 1'b1, 5'd7);
    push("x7_busy_cleared", K_BUSY, 1, 32'h0);
    push("x7_data", K_DATA, 1, 32'hA5);
    step();

    // set and write in the same cycle: set wins
    idle();
    setb(5'd7);
    wr(1, 5'd7, 32'h5A);
    step();
    idle();
    rd(0, 1'b1, 5'd7);
    push("x7_set_wins", K_BUSY, 0, 32'h1);
    push("x7_data2", K_DATA, 0, 32'h5A);
    step();
    idle();
    wr(0, 5'd7, 32'h77);
    step();
    idle();
    rd(0, 1'b1, 5'd7);
    push("x7_busy_clr2", K_BUSY, 0, 32'h0);
    push("x7_data3", K_DATA, 0, 32'h77);
    step();

    // same-cycle read of a written register (bypass-dependent)
    idle();
    setb(5'd3);
    step();
    idle();
    wr(1, 5'd3, 32'hDEAD);
    rd(2, 1'b1, 5'd3);
    push("x3_same_data", K_DATA, 2, BYP ? 32'hDEAD : 32'h0);
    push("x3_same_busy", K_BUSY, 2, BYP ? 32'h0 : 32'h1);
    step();
    idle();
    rd(2, 1'b1, 5'd3);
    push("x3_next_data", K_DATA, 2, 32'hDEAD);
    push("x3_next_busy", K_BUSY, 2, 32'h0);
    step();

    // two ports, different addresses
    idle();
    wr(0, 5'd10, 32'h1010);
    wr(1, 5'd11, 32'h1111);
    step();
    idle();
    rd(0, 1'b1, 5'd10);
    rd(1, 1'b1, 5'd11);
    push("x10", K_DATA, 0, 32'h1010);
    push("x11", K_DATA, 1, 32'h1111);
    step();

    // mark x12 pending, then reset mid-operation and again mid-sweep
    idle();
    setb(5'd12);
    step();
    idle();
    rst = 1'b0;
    #1;
    push("ready_async_rst", K_READY, 0, 32'h0);
    drain();
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    push("ready_mid_sweep", K_READY, 0, 32'h0);
    drain();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    wait_ready("restart");
    idle();
    rd(0, 1'b1, 5'd5);
    rd(1, 1'b1, 5'd10);
    rd(2, 1'b1, 5'd12);
    push("x5_rezeroed", K_DATA, 0, 32'h0);
    push("x10_rezeroed", K_DATA, 1, 32'h0);
    push("x12_busy_reset", K_BUSY, 2, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
